// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: handshake FSM state encodings and default geometry.
// No logic; imported by the dispatchers and the column_adder worker.
// Defaults describe a 4x4 matrix of IEEE-754 single-precision cells.
package coproc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int SIZE_DEFAULT       = 4;
  localparam int CELL_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/column_slice.sv
// Extracts column `col` of a row-major size x size matrix as a packed vector.
// Purely combinational, zero latency.
// No handshake; the caller decides when the result is valid.
module column_slice #(
  parameter int size       = 4,
  parameter int cell_width = 32,
  parameter int col_w      = $clog2(size + 1)
) (
  input  logic [size*size*cell_width-1:0] matrix,
  input  logic [col_w-1:0]                col,
  output logic [size*cell_width-1:0]      column
);

  // Mux each row's cell for the selected column into its row slot.
  always_comb begin
    column = '0;
    for (int r = 0; r < size; r++) begin
      for (int c = 0; c < size; c++) begin
        if (col == c[col_w-1:0]) begin
          column[r*cell_width +: cell_width] = matrix[(r*size+c)*cell_width +: cell_width];
        end
      end
    end
  end

endmodule

// File: rtl/column_sum_dispatcher.sv
// Latches a matrix, feeds one column at a time to a column_adder worker, collects the sums.
// Per column: one cycle to present, worker latency, then ack until worker drops ready.
// Upstream waits on out_ready/in_ack; the worker is paced by ready/ack in both directions.
module column_sum_dispatcher
  import coproc_pkg::*;
#(
  parameter int size       = SIZE_DEFAULT,
  parameter int cell_width = CELL_WIDTH_DEFAULT,
  parameter int width      = cell_width * size
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic [size*width-1:0] in_matrix,
  input  logic                  in_ready,
  input  logic                  in_ack,
  output logic                  out_ready,
  output logic [width-1:0]      out_sums,
  output logic [width-1:0]      out_col,
  output logic                  out_col_ready,
  input  logic [cell_width-1:0] in_sum,
  input  logic                  in_sum_ready,
  output logic                  out_sum_ack
);

  localparam int col_w = $clog2(size + 1);
  localparam logic [col_w-1:0] last_col = col_w'(size - 1);

  state_t              state;
  state_t              state_next;
  logic [col_w-1:0]    r_col;
  logic [size*width-1:0] r_matrix;
  logic [width-1:0]    column;

  column_slice #(
    .size       (size),
    .cell_width (cell_width),
    .col_w      (col_w)
  ) u_slice (
    .matrix (r_matrix),
    .col    (r_col),
    .column (column)
  );

  // State register.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs decoded from the current state.
  always_comb begin
    state_next    = state;
    out_ready     = 1'b0;
    out_col_ready = 1'b0;
    out_sum_ack   = 1'b0;
    out_col       = '0;
    case (state)
      S_IDLE: begin
        if (in_ready) state_next = S_SEND;
      end
      S_SEND: begin
        out_col_ready = 1'b1;
        out_col       = column;
        if (in_sum_ready) state_next = S_ACK;
      end
      S_ACK: begin
        // Wait for the worker to drop ready so a lingering sum is not captured twice.
        out_sum_ack = 1'b1;
        if (!in_sum_ready) state_next = (r_col == last_col) ? S_DONE : S_SEND;
      end
      S_DONE: begin
        out_ready = 1'b1;
        if (in_ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Matrix latch, column counter and result bank; sums are stored bit-exact.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_matrix <= '0;
      r_col    <= '0;
      out_sums <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          r_col <= '0;
          if (in_ready) begin
            r_matrix <= in_matrix;
            out_sums <= '0;
          end
        end
        S_SEND: begin
          if (in_sum_ready) begin
            for (int c = 0; c < size; c++) begin
              if (r_col == c[col_w-1:0]) out_sums[c*cell_width +: cell_width] <= in_sum;
            end
          end
        end
        S_ACK: begin
          if (!in_sum_ready) r_col <= r_col + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
